// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: round-robin CDB/ROB result bus arbiter and registered mux (clk, rst, per-FU cdb_*/rob_* requests in, one-hot grants and registered bus/ROB payloads out); ARB_STATS_EN adds a saturating cdb_conflicts counter
module result_bus_arbiter #(
  parameter int NUM_FU = 4,
  parameter int ID_W = 4,
  parameter int VAL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       cdb_req,
  input  logic [NUM_FU*ID_W-1:0]  cdb_id_in,
  input  logic [NUM_FU*VAL_W-1:0] cdb_val_in,
  output logic [NUM_FU-1:0]       cdb_grant,
  input  logic [NUM_FU-1:0]       rob_req,
  input  logic [NUM_FU*ID_W-1:0]  rob_robid_in,
  input  logic [NUM_FU*VAL_W-1:0] rob_flags_in,
  input  logic [NUM_FU*VAL_W-1:0] rob_wbs_in,
  input  logic [NUM_FU*VAL_W-1:0] rob_value_in,
  input  logic                    rob_ready,
  output logic [NUM_FU-1:0]       rob_grant,
  output logic                    bus_valid,
  output logic [ID_W-1:0]         bus_id,
  output logic [VAL_W-1:0]        bus_val,
  output logic                    rob_wr,
  output logic [ID_W-1:0]         rob_robid,
  output logic [VAL_W-1:0]        rob_flags,
  output logic [VAL_W-1:0]        rob_wbs,
  output logic [VAL_W-1:0]        rob_value
`ifdef ARB_STATS_EN
  , output logic [15:0]           cdb_conflicts
`endif
);
  localparam int PW = $clog2(NUM_FU);
  function automatic logic [PW:0] pick(input logic [NUM_FU-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] j;
    pick = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NUM_FU);
      if (req[j]) pick = {1'b1, j};
    end
  endfunction
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] w);
    return (w == PW'(NUM_FU - 1)) ? '0 : w + 1'b1;
  endfunction
  logic [PW-1:0] cdb_ptr, rob_ptr, cdb_win, rob_win;
  logic cdb_any, rob_any, cdb_go, rob_go;
  assign {cdb_any, cdb_win} = pick(cdb_req, cdb_ptr);
  assign {rob_any, rob_win} = pick(rob_req, rob_ptr);
  assign cdb_go = cdb_any & ~rst;
  assign rob_go = rob_any & rob_ready & ~rst;
  assign cdb_grant = cdb_go ? NUM_FU'(1) << cdb_win : '0;
  assign rob_grant = rob_go ? NUM_FU'(1) << rob_win : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_ptr <= '0;
      rob_ptr <= '0;
      bus_valid <= 1'b0;
      bus_id <= '0;
      bus_val <= '0;
      rob_wr <= 1'b0;
      rob_robid <= '0;
      rob_flags <= '0;
      rob_wbs <= '0;
      rob_value <= '0;
    end else begin
      bus_valid <= cdb_go;
      rob_wr <= rob_go;
      if (cdb_go) begin
        cdb_ptr <= nxt(cdb_win);
        bus_id <= cdb_id_in[cdb_win*ID_W +: ID_W];
        bus_val <= cdb_val_in[cdb_win*VAL_W +: VAL_W];
      end
      if (rob_go) begin
        rob_ptr <= nxt(rob_win);
        rob_robid <= rob_robid_in[rob_win*ID_W +: ID_W];
        rob_flags <= rob_flags_in[rob_win*VAL_W +: VAL_W];
        rob_wbs <= rob_wbs_in[rob_win*VAL_W +: VAL_W];
        rob_value <= rob_value_in[rob_win*VAL_W +: VAL_W];
      end
    end
  end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) cdb_conflicts <= '0;
    else if ($countones(cdb_req) > 1 && cdb_conflicts != 16'hFFFF) cdb_conflicts <= cdb_conflicts + 1'b1;
  end
`endif
endmodule
